wb_data_router: RTL and testbench

- Single-master to two-slave Wishbone (pipelined, with stall) router for the core's data port.
- Sits between the core's data bus and its targets: slave 0 is main memory, slave 1 is the peripheral window (UART/GPIO).
- Decodes the address, forwards one transaction at a time, and returns ack and read data to the core.
- Generates an error response for unmapped addresses and for slaves that do not ack within a timeout.

---
 rtl/wb_data_router.sv | 174 +++++++++++++++++
 tb/tb_wb_data_router.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_data_router.sv
// rtl/wb_data_router.sv - single-master, two-slave pipelined Wishbone router with decode and timeout
module wb_data_router #(
    parameter logic [31:0] MEM_BASE       = 32'h0000_0000,
    parameter logic [31:0] MEM_SIZE       = 32'd81920,
    parameter logic [31:0] PERIPH_BASE    = 32'h8000_0000,
    parameter logic [31:0] PERIPH_SIZE    = 32'h0000_1000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_addr,
    input  logic [31:0] i_wb_data,
    input  logic [3:0]  i_wb_sel,
    output logic        o_wb_ack,
    output logic        o_wb_stall,
    output logic [31:0] o_wb_data,
    output logic        o_wb_err,
    output logic [1:0]  o_s_cyc,
    output logic [1:0]  o_s_stb,
    output logic        o_s_we,
    output logic [31:0] o_s_addr,
    output logic [31:0] o_s_data,
    output logic [3:0]  o_s_sel,
    input  logic [1:0]  i_s_ack,
    input  logic [1:0]  i_s_stall,
    input  logic [31:0] i_s_data0,
    input  logic [31:0] i_s_data1
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t        state, state_d;
    logic          idx, idx_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          ack_d, err_d, we_d;
    logic [31:0]   rdata_d, addr_d, wdata_d;
    logic [1:0]    cyc_d, stb_d;
    logic [3:0]    sel_d;
    logic          hit_mem, hit_periph, slv_ack, slv_stall;
    logic [31:0]   slv_data;

    // 33-bit compare keeps windows near the top of the address space from wrapping
    function automatic logic in_window(input logic [31:0] a, input logic [31:0] base,
                                       input logic [31:0] size);
        logic [32:0] off;
        off = {1'b0, a} - {1'b0, base};
        return ({1'b0, a} >= {1'b0, base}) && (off < {1'b0, size});
    endfunction

    assign hit_mem    = in_window(i_wb_addr, MEM_BASE, MEM_SIZE);
    assign hit_periph = in_window(i_wb_addr, PERIPH_BASE, PERIPH_SIZE);
    assign slv_ack    = i_s_ack[idx];
    assign slv_stall  = i_s_stall[idx];
    assign slv_data   = idx ? i_s_data1 : i_s_data0;
    assign o_wb_stall = (state != S_IDLE);

    always_comb begin
        state_d = state;
        idx_d   = idx;
        cnt_d   = cnt;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rdata_d = o_wb_data;
        cyc_d   = o_s_cyc;
        stb_d   = o_s_stb;
        we_d    = o_s_we;
        addr_d  = o_s_addr;
        wdata_d = o_s_data;
        sel_d   = o_s_sel;
        case (state)
            S_IDLE: begin
                if (i_wb_cyc && i_wb_stb) begin
                    we_d    = i_wb_we;
                    addr_d  = i_wb_addr;
                    wdata_d = i_wb_data;
                    sel_d   = i_wb_sel;
                    if (hit_mem) begin
                        idx_d   = 1'b0;
                        cyc_d   = 2'b01;
                        stb_d   = 2'b01;
                        state_d = S_ISSUE;
                    end else if (hit_periph) begin
                        idx_d   = 1'b1;
                        cyc_d   = 2'b10;
                        stb_d   = 2'b10;
                        state_d = S_ISSUE;
                    end else begin
                        ack_d   = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = 32'h0;
                        state_d = S_RESP;
                    end
                end
            end
            S_ISSUE: begin
                if (!i_wb_cyc) begin
                    cyc_d   = 2'b00;
                    stb_d   = 2'b00;
                    state_d = S_IDLE;
                end else if (!slv_stall) begin
                    stb_d = 2'b00;
                    if (slv_ack) begin
                        rdata_d = slv_data;
                        cyc_d   = 2'b00;
                        ack_d   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        cnt_d   = '0;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!i_wb_cyc) begin
                    cyc_d   = 2'b00;
                    stb_d   = 2'b00;
                    state_d = S_IDLE;
                end else if (slv_ack) begin
                    rdata_d = slv_data;
                    cyc_d   = 2'b00;
                    ack_d   = 1'b1;
                    state_d = S_RESP;
                end else if (cnt == CNT_LAST) begin
                    rdata_d = 32'h0;
                    cyc_d   = 2'b00;
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= S_IDLE;
            idx       <= 1'b0;
            cnt       <= '0;
            o_wb_ack  <= 1'b0;
            o_wb_err  <= 1'b0;
            o_wb_data <= 32'h0;
            o_s_cyc   <= 2'b00;
            o_s_stb   <= 2'b00;
            o_s_we    <= 1'b0;
            o_s_addr  <= 32'h0;
            o_s_data  <= 32'h0;
            o_s_sel   <= 4'h0;
        end else begin
            state     <= state_d;
            idx       <= idx_d;
            cnt       <= cnt_d;
            o_wb_ack  <= ack_d;
            o_wb_err  <= err_d;
            o_wb_data <= rdata_d;
            o_s_cyc   <= cyc_d;
            o_s_stb   <= stb_d;
            o_s_we    <= we_d;
            o_s_addr  <= addr_d;
            o_s_data  <= wdata_d;
            o_s_sel   <= sel_d;
        end
    end

endmodule

// File: tb/tb_wb_data_router.sv
// tb/tb_wb_data_router.sv - directed bench for wb_data_router with behavioural slaves
module tb_wb_data_router;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_cyc, wb_stb, wb_we;
    logic [31:0] wb_addr, wb_wdata;
    logic [3:0]  wb_sel;
    logic        wb_ack, wb_stall, wb_err;
    logic [31:0] wb_rdata;
    logic [1:0]  s_cyc, s_stb;
    logic        s_we;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_sel;
    logic [1:0]  s_ack, s_stall;
    logic [31:0] s_data0, s_data1;

    int n_vec = 0;
    int n_err = 0;

    logic [1:0] en, late, pend;
    int         left [2];

    logic [31:0] dec_addr [6] = '{32'h0001_3FFC, 32'h0001_4000, 32'h8000_0FFC,
                                  32'h8000_1000, 32'h7FFF_FFFC, 32'h8000_0000};
    logic [1:0]  dec_exp  [6] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'b10};

    wb_data_router dut (
        .i_clk(clk), .i_rst(rst),
        .i_wb_cyc(wb_cyc), .i_wb_stb(wb_stb), .i_wb_we(wb_we),
        .i_wb_addr(wb_addr), .i_wb_data(wb_wdata), .i_wb_sel(wb_sel),
        .o_wb_ack(wb_ack), .o_wb_stall(wb_stall), .o_wb_data(wb_rdata), .o_wb_err(wb_err),
        .o_s_cyc(s_cyc), .o_s_stb(s_stb), .o_s_we(s_we),
        .o_s_addr(s_addr), .o_s_data(s_wdata), .o_s_sel(s_sel),
        .i_s_ack(s_ack), .i_s_stall(s_stall), .i_s_data0(s_data0), .i_s_data1(s_data1)
    );

    always #5 clk = ~clk;

    // Slaves: stall for left[n] cycles, then ack one cycle after acceptance when enabled
    initial begin
        s_ack = 2'b00; s_stall = 2'b00; s_data0 = 32'h0; s_data1 = 32'h0;
        en = 2'b11; late = 2'b00; pend = 2'b00; left[0] = 0; left[1] = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                s_ack = 2'b00; s_stall = 2'b00; pend = 2'b00; left[0] = 0; left[1] = 0;
            end else begin
                for (int n = 0; n < 2; n++) begin
                    s_ack[n] = (pend[n] && en[n]) || late[n];
                    late[n]  = 1'b0;
                    if (s_stb[n] && left[n] > 0) begin
                        s_stall[n] = 1'b1;
                        left[n]    = left[n] - 1;
                    end else begin
                        s_stall[n] = 1'b0;
                    end
                    pend[n] = s_stb[n] && !s_stall[n];
                end
            end
            s_data0 = (s_addr == 32'h10) ? 32'h1234_5678 : ~s_addr;
            s_data1 = 32'hC0DE_0001;
        end
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_addr = a; wb_wdata = d; wb_sel = s;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick; #1;
        n_vec++; if (wb_ack !== 1'b0) begin n_err++; $display("FAIL rst_ack: got %h want 0", wb_ack); end
        n_vec++; if (wb_err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %h want 0", wb_err); end
        n_vec++; if (wb_rdata !== 32'h0) begin n_err++; $display("FAIL rst_data: got %h want 0", wb_rdata); end
        n_vec++; if ({s_cyc, s_stb} !== 4'h0) begin n_err++; $display("FAIL rst_cycstb: got %h want 0", {s_cyc, s_stb}); end
        n_vec++; if ({s_we, s_addr, s_wdata, s_sel} !== 69'h0) begin n_err++; $display("FAIL rst_sbus: got %h want 0", {s_we, s_addr, s_wdata, s_sel}); end
        n_vec++; if (wb_stall !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %h want 0", wb_stall); end
        tick; #2 rst = 1'b0;
    endtask

    task automatic test_read_mem;
        tick; drive(1'b0, 32'h10, 32'h0, 4'hF);
        tick;
        n_vec++; if (s_stb !== 2'b01) begin n_err++; $display("FAIL rd_stb: got %b want 01", s_stb); end
        n_vec++; if (s_cyc !== 2'b01) begin n_err++; $display("FAIL rd_cyc: got %b want 01", s_cyc); end
        n_vec++; if (s_addr !== 32'h10) begin n_err++; $display("FAIL rd_addr: got %h want 10", s_addr); end
        n_vec++; if (wb_stall !== 1'b1) begin n_err++; $display("FAIL rd_stall: got %h want 1", wb_stall); end
        wb_stb = 1'b0;
        tick;
        n_vec++; if (wb_ack !== 1'b0) begin n_err++; $display("FAIL rd_ack_early: got %h want 0", wb_ack); end
        tick;
        n_vec++; if (wb_ack !== 1'b1) begin n_err++; $display("FAIL rd_ack: got %h want 1", wb_ack); end
        n_vec++; if (wb_err !== 1'b0) begin n_err++; $display("FAIL rd_err: got %h want 0", wb_err); end
        n_vec++; if (wb_rdata !== 32'h1234_5678) begin n_err++; $display("FAIL rd_data: got %h want 12345678", wb_rdata); end
        n_vec++; if (s_cyc !== 2'b00) begin n_err++; $display("FAIL rd_cyc_resp: got %b want 00", s_cyc); end
        tick;
        n_vec++; if ({wb_ack, wb_stall} !== 2'b00) begin n_err++; $display("FAIL rd_after: got %b want 00", {wb_ack, wb_stall}); end
        wb_cyc = 1'b0;
    endtask

    task automatic test_write_periph;
        tick; drive(1'b1, 32'h8000_0004, 32'hA5, 4'b0001);
        tick;
        n_vec++; if (s_stb !== 2'b10) begin n_err++; $display("FAIL wr_stb: got %b want 10", s_stb); end
        n_vec++; if (s_addr !== 32'h8000_0004) begin n_err++; $display("FAIL wr_addr: got %h want 80000004", s_addr); end
        n_vec++; if ({s_we, s_sel} !== 5'b1_0001) begin n_err++; $display("FAIL wr_we_sel: got %b want 10001", {s_we, s_sel}); end
        n_vec++; if (s_wdata !== 32'hA5) begin n_err++; $display("FAIL wr_wdata: got %h want a5", s_wdata); end
        wb_stb = 1'b0;
        tick; tick;
        n_vec++; if ({wb_ack, wb_err} !== 2'b10) begin n_err++; $display("FAIL wr_ack_err: got %b want 10", {wb_ack, wb_err}); end
        n_vec++; if (wb_rdata !== 32'hC0DE_0001) begin n_err++; $display("FAIL wr_data: got %h want c0de0001", wb_rdata); end
        tick; wb_cyc = 1'b0;
    endtask

    task automatic test_unmapped;
        tick; drive(1'b0, 32'h4000_0000, 32'h0, 4'hF);
        tick;
        n_vec++; if ({wb_ack, wb_err} !== 2'b11) begin n_err++; $display("FAIL um_ack_err: got %b want 11", {wb_ack, wb_err}); end
        n_vec++; if (wb_rdata !== 32'h0) begin n_err++; $display("FAIL um_data: got %h want 0", wb_rdata); end
        n_vec++; if (s_cyc !== 2'b00) begin n_err++; $display("FAIL um_cyc: got %b want 00", s_cyc); end
        wb_stb = 1'b0;
        tick;
        n_vec++; if ({wb_ack, wb_err} !== 2'b00) begin n_err++; $display("FAIL um_clear: got %b want 00", {wb_ack, wb_err}); end
        wb_cyc = 1'b0;
    endtask

    task automatic test_decode_boundary;
        for (int i = 0; i < 6; i++) begin
            tick; drive(1'b0, dec_addr[i], 32'h0, 4'hF);
            tick;
            n_vec++; if (s_cyc !== dec_exp[i]) begin n_err++; $display("FAIL dec_cyc[%0d]: got %b want %b", i, s_cyc, dec_exp[i]); end
            n_vec++; if ({wb_ack, wb_err} !== ((dec_exp[i] == 2'b00) ? 2'b11 : 2'b00)) begin n_err++; $display("FAIL dec_resp[%0d]: got %b want %b", i, {wb_ack, wb_err}, (dec_exp[i] == 2'b00) ? 2'b11 : 2'b00); end
            wb_stb = 1'b0;
            tick; tick; tick;
            wb_cyc = 1'b0;
        end
    endtask

    task automatic test_timeout;
        en[1] = 1'b0;
        tick; drive(1'b0, 32'h8000_0010, 32'h0, 4'hF);
        tick;
        n_vec++; if (s_stb !== 2'b10) begin n_err++; $display("FAIL to_stb: got %b want 10", s_stb); end
        wb_stb = 1'b0;
        for (int k = 2; k < 18; k++) begin
            tick;
            n_vec++; if (wb_ack !== 1'b0) begin n_err++; $display("FAIL to_early_ack@%0d: got %h want 0", k, wb_ack); end
        end
        n_vec++; if (s_cyc !== 2'b10) begin n_err++; $display("FAIL to_cyc_wait: got %b want 10", s_cyc); end
        tick;
        n_vec++; if ({wb_ack, wb_err} !== 2'b11) begin n_err++; $display("FAIL to_ack_err: got %b want 11", {wb_ack, wb_err}); end
        n_vec++; if (wb_rdata !== 32'h0) begin n_err++; $display("FAIL to_data: got %h want 0", wb_rdata); end
        n_vec++; if (s_cyc !== 2'b00) begin n_err++; $display("FAIL to_cyc: got %b want 00", s_cyc); end
        wb_cyc = 1'b0; en[1] = 1'b1; late[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick;
            n_vec++; if (wb_ack !== 1'b0) begin n_err++; $display("FAIL to_late_ack@%0d: got %h want 0", k, wb_ack); end
        end
    endtask

    task automatic test_back_to_back;
        left[0] = 3;
        tick; drive(1'b0, 32'h10, 32'h0, 4'hF);
        tick;
        n_vec++; if ({s_stb, wb_stall} !== 3'b011) begin n_err++; $display("FAIL b2b_stb@1: got %b want 011", {s_stb, wb_stall}); end
        wb_addr = 32'h20;
        for (int k = 2; k < 5; k++) begin
            tick;
            n_vec++; if ({s_stb, wb_stall} !== 3'b011) begin n_err++; $display("FAIL b2b_stb@%0d: got %b want 011", k, {s_stb, wb_stall}); end
        end
        tick;
        n_vec++; if ({s_stb, wb_stall} !== 3'b001) begin n_err++; $display("FAIL b2b_wait: got %b want 001", {s_stb, wb_stall}); end
        tick;
        n_vec++; if ({wb_ack, wb_stall} !== 2'b11) begin n_err++; $display("FAIL b2b_ack1: got %b want 11", {wb_ack, wb_stall}); end
        n_vec++; if (wb_rdata !== 32'h1234_5678) begin n_err++; $display("FAIL b2b_data1: got %h want 12345678", wb_rdata); end
        tick;
        n_vec++; if ({wb_ack, wb_stall} !== 2'b00) begin n_err++; $display("FAIL b2b_idle: got %b want 00", {wb_ack, wb_stall}); end
        tick;
        n_vec++; if (s_stb !== 2'b01) begin n_err++; $display("FAIL b2b_stb2: got %b want 01", s_stb); end
        n_vec++; if (s_addr !== 32'h20) begin n_err++; $display("FAIL b2b_addr2: got %h want 20", s_addr); end
        wb_stb = 1'b0;
        tick; tick;
        n_vec++; if (wb_ack !== 1'b1) begin n_err++; $display("FAIL b2b_ack2: got %h want 1", wb_ack); end
        n_vec++; if (wb_rdata !== 32'hFFFF_FFDF) begin n_err++; $display("FAIL b2b_data2: got %h want ffffffdf", wb_rdata); end
        wb_cyc = 1'b0;
        tick;
    endtask

    task automatic test_abort;
        en[0] = 1'b0;
        tick; drive(1'b0, 32'h10, 32'h0, 4'hF);
        tick;
        n_vec++; if (s_cyc !== 2'b01) begin n_err++; $display("FAIL ab_cyc: got %b want 01", s_cyc); end
        wb_stb = 1'b0;
        tick;
        n_vec++; if ({s_cyc, s_stb} !== 4'b0100) begin n_err++; $display("FAIL ab_wait: got %b want 0100", {s_cyc, s_stb}); end
        wb_cyc = 1'b0;
        tick;
        n_vec++; if ({s_cyc, s_stb, wb_stall, wb_ack} !== 6'b0) begin n_err++; $display("FAIL ab_drop: got %b want 000000", {s_cyc, s_stb, wb_stall, wb_ack}); end
        n_vec++; if (wb_rdata !== 32'hFFFF_FFDF) begin n_err++; $display("FAIL ab_data: got %h want ffffffdf", wb_rdata); end
        for (int k = 0; k < 3; k++) begin
            tick;
            n_vec++; if (wb_ack !== 1'b0) begin n_err++; $display("FAIL ab_noack@%0d: got %h want 0", k, wb_ack); end
        end
        en[0] = 1'b1;
    endtask

    task automatic test_async_reset;
        left[1] = 10;
        tick; drive(1'b1, 32'h8000_0008, 32'h55, 4'hF);
        tick;
        n_vec++; if ({s_cyc, s_stb} !== 4'b1010) begin n_err++; $display("FAIL ar_issue: got %b want 1010", {s_cyc, s_stb}); end
        #2 rst = 1'b1;
        #1;
        n_vec++; if ({s_cyc, s_stb, wb_stall, wb_ack, wb_err} !== 7'b0) begin n_err++; $display("FAIL ar_ctrl: got %b want 0000000", {s_cyc, s_stb, wb_stall, wb_ack, wb_err}); end
        n_vec++; if ({s_we, s_addr, s_wdata, s_sel} !== 69'h0) begin n_err++; $display("FAIL ar_sbus: got %h want 0", {s_we, s_addr, s_wdata, s_sel}); end
        n_vec++; if (wb_rdata !== 32'h0) begin n_err++; $display("FAIL ar_data: got %h want 0", wb_rdata); end
        wb_cyc = 1'b0; wb_stb = 1'b0;
        tick; #2 rst = 1'b0;
        tick;
    endtask

    initial begin
        rst = 1'b1;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        wb_addr = 32'h0; wb_wdata = 32'h0; wb_sel = 4'h0;
        test_reset;
        test_read_mem;
        test_write_periph;
        test_unmapped;
        test_decode_boundary;
        test_timeout;
        test_back_to_back;
        test_abort;
        test_async_reset;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
